// File: rtl/mvm_param.sv
// mvm_param: parametrised signed matrix-vector multiplier, y = A*x.
// A (KxK) and x (Kx1) stream in word-serially on data_in and are kept
// until reloaded. y streams out word-serially on data_out after a compute
// phase that uses P parallel MAC lanes; lane p handles rows p, p+P, ...
// Optional feature: define MVM_SAT_EN to clamp y to the OUTW range and
// report clamping on ovf. Without it, y wraps and ovf is tied low.
module mvm_param #(
    parameter int K    = 8,
    parameter int B    = 8,
    parameter int OUTW = 16,
    parameter int P    = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   loadMatrix,
    input  logic                   loadVector,
    input  logic                   start,
    input  logic signed [B-1:0]    data_in,
    output logic                   busy,
    output logic                   done,
    output logic                   out_valid,
    output logic signed [OUTW-1:0] data_out,
    output logic                   ovf
);

    localparam int ACCW = 2 * B + $clog2(K);
    localparam int KW   = $clog2(K);
    localparam int MW   = $clog2(K * K);
    localparam int G    = K / P;
    localparam int GW   = (G > 1) ? $clog2(G) : 1;
    localparam int OW   = $clog2(K + 1);

    generate
        if (K % P != 0) begin : g_bad_p
            $error("mvm_param: K must be a multiple of P");
        end
    endgenerate

    typedef enum logic [2:0] {IDLE, LOAD_M, LOAD_V, COMPUTE, DRAIN} state_t;

    state_t                 state_reg;
    logic                   m_loaded_reg;
    logic                   v_loaded_reg;
    logic [MW-1:0]          mcnt_reg;
    logic [KW-1:0]          vcnt_reg;
    logic [KW-1:0]          col_reg;
    logic [GW-1:0]          grp_reg;
    logic [OW-1:0]          oidx_reg;

    logic signed [B-1:0]    a_mem [K*K];
    logic signed [B-1:0]    x_mem [K];
    logic signed [OUTW-1:0] y_mem [K];

    logic signed [ACCW-1:0] acc_reg [P];
    logic signed [2*B-1:0]  prod    [P];
    logic signed [ACCW-1:0] sum     [P];
    logic signed [OUTW-1:0] yval    [P];

    logic row_end;
    logic grp_end;
    logic start_ok;

    assign row_end  = (col_reg == KW'(K - 1));
    assign grp_end  = (grp_reg == GW'(G - 1));
    // start wins only when no load request competes in the same cycle
    assign start_ok = (state_reg == IDLE) && !loadMatrix && !loadVector &&
                      start && m_loaded_reg && v_loaded_reg;

`ifdef MVM_SAT_EN
    logic clip [P];
`endif

    // Per-lane datapath: fetch A[row][col]*x[col], accumulate, convert to OUTW
    genvar gi;
    generate
        for (gi = 0; gi < P; gi++) begin : g_lane
            logic [MW-1:0] addr;
            assign addr     = MW'((int'(grp_reg) * P + gi) * K + int'(col_reg));
            assign prod[gi] = (2*B)'(a_mem[addr]) * (2*B)'(x_mem[col_reg]);
            assign sum[gi]  = acc_reg[gi] + ACCW'(prod[gi]);
`ifdef MVM_SAT_EN
            if (OUTW < ACCW) begin : g_sat
                logic [ACCW-OUTW:0] hi;
                assign hi       = sum[gi][ACCW-1:OUTW-1];
                assign clip[gi] = !((&hi) || (~|hi));
                assign yval[gi] = !clip[gi] ? sum[gi][OUTW-1:0] :
                                  sum[gi][ACCW-1] ? {1'b1, {(OUTW-1){1'b0}}} :
                                                    {1'b0, {(OUTW-1){1'b1}}};
            end else begin : g_nosat
                assign clip[gi] = 1'b0;
                assign yval[gi] = OUTW'(sum[gi]);
            end
`else
            assign yval[gi] = OUTW'(sum[gi]);
`endif
        end
    endgenerate

    // Operand and result storage; written from the FSM's current state
    always_ff @(posedge clk) begin
        if (state_reg == LOAD_M)
            a_mem[mcnt_reg] <= data_in;
        if (state_reg == LOAD_V)
            x_mem[vcnt_reg] <= data_in;
        if (state_reg == COMPUTE && row_end)
            for (int p = 0; p < P; p++)
                y_mem[KW'(int'(grp_reg) * P + p)] <= yval[p];
    end

    // Control FSM with registered status/result outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            m_loaded_reg <= 1'b0;
            v_loaded_reg <= 1'b0;
            mcnt_reg     <= '0;
            vcnt_reg     <= '0;
            col_reg      <= '0;
            grp_reg      <= '0;
            oidx_reg     <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            out_valid    <= 1'b0;
            data_out     <= '0;
            for (int p = 0; p < P; p++)
                acc_reg[p] <= '0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (loadMatrix) begin
                        state_reg    <= LOAD_M;
                        m_loaded_reg <= 1'b0;
                        mcnt_reg     <= '0;
                        busy         <= 1'b1;
                    end else if (loadVector) begin
                        state_reg    <= LOAD_V;
                        v_loaded_reg <= 1'b0;
                        vcnt_reg     <= '0;
                        busy         <= 1'b1;
                    end else if (start_ok) begin
                        state_reg <= COMPUTE;
                        col_reg   <= '0;
                        grp_reg   <= '0;
                        busy      <= 1'b1;
                        for (int p = 0; p < P; p++)
                            acc_reg[p] <= '0;
                    end
                end
                LOAD_M: begin
                    mcnt_reg <= mcnt_reg + MW'(1);
                    if (mcnt_reg == MW'(K * K - 1)) begin
                        state_reg    <= IDLE;
                        m_loaded_reg <= 1'b1;
                        busy         <= 1'b0;
                    end
                end
                LOAD_V: begin
                    vcnt_reg <= vcnt_reg + KW'(1);
                    if (vcnt_reg == KW'(K - 1)) begin
                        state_reg    <= IDLE;
                        v_loaded_reg <= 1'b1;
                        busy         <= 1'b0;
                    end
                end
                COMPUTE: begin
                    for (int p = 0; p < P; p++)
                        acc_reg[p] <= row_end ? '0 : sum[p];
                    col_reg <= row_end ? '0 : col_reg + KW'(1);
                    if (row_end) begin
                        grp_reg <= grp_reg + GW'(1);
                        if (grp_end) begin
                            state_reg <= DRAIN;
                            oidx_reg  <= '0;
                        end
                    end
                end
                DRAIN: begin
                    if (oidx_reg == OW'(K)) begin
                        out_valid <= 1'b0;
                        state_reg <= IDLE;
                        busy      <= 1'b0;
                    end else begin
                        data_out  <= y_mem[oidx_reg[KW-1:0]];
                        out_valid <= 1'b1;
                        done      <= (oidx_reg == '0);
                        oidx_reg  <= oidx_reg + OW'(1);
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

`ifdef MVM_SAT_EN
    logic ovf_reg;

    // Sticky clamp flag, cleared when a new run is accepted
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_reg <= 1'b0;
        end else if (start_ok) begin
            ovf_reg <= 1'b0;
        end else if (state_reg == COMPUTE && row_end) begin
            for (int p = 0; p < P; p++)
                if (clip[p])
                    ovf_reg <= 1'b1;
        end
    end

    assign ovf = ovf_reg;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_mvm_param.sv
// Self-checking bench for mvm_param: a P=1 and a P=4 instance share all
// inputs; each has its own scoreboard queue of expected y words.
`timescale 1ns/1ps
module tb_mvm_param;

    localparam int K    = 8;
    localparam int B    = 8;
    localparam int OUTW = 16;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic loadMatrix = 1'b0;
    logic loadVector = 1'b0;
    logic start = 1'b0;
    logic signed [B-1:0] data_in = '0;

    logic busy1, done1, ov1, ovf1;
    logic signed [OUTW-1:0] dout1;
    logic busy4, done4, ov4, ovf4;
    logic signed [OUTW-1:0] dout4;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    int amat [K*K];
    int xvec [K];
    logic signed [OUTW-1:0] exp_y [K];
    logic exp_ovf;
    logic signed [OUTW-1:0] q1 [$];
    logic signed [OUTW-1:0] q4 [$];

    always #5 clk = ~clk;

    mvm_param #(.K(K), .B(B), .OUTW(OUTW), .P(1)) dut1 (
        .clk(clk), .reset(reset), .loadMatrix(loadMatrix), .loadVector(loadVector),
        .start(start), .data_in(data_in), .busy(busy1), .done(done1),
        .out_valid(ov1), .data_out(dout1), .ovf(ovf1)
    );

    mvm_param #(.K(K), .B(B), .OUTW(OUTW), .P(4)) dut4 (
        .clk(clk), .reset(reset), .loadMatrix(loadMatrix), .loadVector(loadVector),
        .start(start), .data_in(data_in), .busy(busy4), .done(done4),
        .out_valid(ov4), .data_out(dout4), .ovf(ovf4)
    );

    // Scoreboard for the P=1 instance
    always @(negedge clk) begin
        if (reset && ov1) begin
            chk_cnt++;
            if (q1.size() == 0) begin
                $display("FAIL y_p1: unexpected output %0d, none expected", dout1);
            end else begin
                logic signed [OUTW-1:0] e;
                e = q1.pop_front();
                if (dout1 !== e) $display("FAIL y_p1: got %0d expected %0d", dout1, e);
                else begin pass_cnt++; $display("y_p1 ok: %0d", dout1); end
            end
        end
    end

    // Scoreboard for the P=4 instance
    always @(negedge clk) begin
        if (reset && ov4) begin
            chk_cnt++;
            if (q4.size() == 0) begin
                $display("FAIL y_p4: unexpected output %0d, none expected", dout4);
            end else begin
                logic signed [OUTW-1:0] e;
                e = q4.pop_front();
                if (dout4 !== e) $display("FAIL y_p4: got %0d expected %0d", dout4, e);
                else begin pass_cnt++; $display("y_p4 ok: %0d", dout4); end
            end
        end
    end

    // Reference model: exact integer product, then wrap or clamp to OUTW
    function automatic void model();
        longint acc;
        longint lim;
        lim = longint'(1) <<< (OUTW - 1);
        exp_ovf = 1'b0;
        for (int i = 0; i < K; i++) begin
            acc = 0;
            for (int j = 0; j < K; j++)
                acc += longint'(amat[i*K+j]) * longint'(xvec[j]);
`ifdef MVM_SAT_EN
            if (acc > lim - 1) begin
                exp_y[i] = OUTW'(lim - 1);
                exp_ovf  = 1'b1;
            end else if (acc < -lim) begin
                exp_y[i] = OUTW'(-lim);
                exp_ovf  = 1'b1;
            end else begin
                exp_y[i] = OUTW'(acc);
            end
`else
            exp_y[i] = OUTW'(acc);
            if (lim == 0) exp_ovf = 1'b1;
`endif
        end
    endfunction

    function automatic void set_identity();
        for (int i = 0; i < K*K; i++) amat[i] = (i / K == i % K) ? 1 : 0;
    endfunction

    function automatic void set_all_a(input int v);
        for (int i = 0; i < K*K; i++) amat[i] = v;
    endfunction

    function automatic void set_x_ramp();
        for (int i = 0; i < K; i++) xvec[i] = i + 1;
    endfunction

    function automatic void set_all_x(input int v);
        for (int i = 0; i < K; i++) xvec[i] = v;
    endfunction

    task automatic load_matrix(input logic with_vec);
        @(negedge clk);
        loadMatrix = 1'b1;
        loadVector = with_vec;
        for (int i = 0; i < K*K; i++) begin
            @(negedge clk);
            loadMatrix = 1'b0;
            loadVector = 1'b0;
            data_in = B'(amat[i]);
        end
        @(negedge clk);
    endtask

    task automatic load_vector();
        @(negedge clk);
        loadVector = 1'b1;
        for (int i = 0; i < K; i++) begin
            @(negedge clk);
            loadVector = 1'b0;
            data_in = B'(xvec[i]);
        end
        @(negedge clk);
    endtask

    // Start a run, push expectations, and check timing, counts and flags
    task automatic run_and_check(input string name);
        int d1, d4, v1, v4, dc1, dc4;
        model();
        for (int i = 0; i < K; i++) begin
            q1.push_back(exp_y[i]);
            q4.push_back(exp_y[i]);
        end
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        d1 = -1; d4 = -1; v1 = 0; v4 = 0; dc1 = 0; dc4 = 0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (done1) begin dc1++; if (d1 < 0) d1 = k; end
            if (done4) begin dc4++; if (d4 < 0) d4 = k; end
            if (ov1) v1++;
            if (ov4) v4++;
        end
        chk_cnt++;
        if (d1 !== 65) $display("FAIL %s_lat_p1: got %0d expected 65", name, d1);
        else pass_cnt++;
        chk_cnt++;
        if (d4 !== 17) $display("FAIL %s_lat_p4: got %0d expected 17", name, d4);
        else pass_cnt++;
        chk_cnt++;
        if (v1 !== K || dc1 !== 1) $display("FAIL %s_cnt_p1: valid %0d done %0d expected %0d 1", name, v1, dc1, K);
        else pass_cnt++;
        chk_cnt++;
        if (v4 !== K || dc4 !== 1) $display("FAIL %s_cnt_p4: valid %0d done %0d expected %0d 1", name, v4, dc4, K);
        else pass_cnt++;
        chk_cnt++;
        if (q1.size() != 0 || q4.size() != 0) $display("FAIL %s_drain: left %0d/%0d expected 0", name, q1.size(), q4.size());
        else pass_cnt++;
        q1.delete();
        q4.delete();
        chk_cnt++;
        if (ovf1 !== exp_ovf || ovf4 !== exp_ovf) $display("FAIL %s_ovf: got %b/%b expected %b", name, ovf1, ovf4, exp_ovf);
        else pass_cnt++;
        chk_cnt++;
        if (busy1 !== 1'b0 || busy4 !== 1'b0) $display("FAIL %s_idle: busy %b/%b expected 0", name, busy1, busy4);
        else pass_cnt++;
        chk_cnt++;
        if (dout1 !== exp_y[K-1] || dout4 !== exp_y[K-1]) $display("FAIL %s_hold: got %0d/%0d expected %0d", name, dout1, dout4, exp_y[K-1]);
        else pass_cnt++;
        $display("run %s: done p1=%0d p4=%0d ovf=%b", name, d1, d4, ovf1);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk_cnt++;
        if ({busy1, done1, ov1, ovf1, dout1} !== '0) $display("FAIL reset_p1: got %h expected 0", {busy1, done1, ov1, ovf1, dout1});
        else pass_cnt++;
        chk_cnt++;
        if ({busy4, done4, ov4, ovf4, dout4} !== '0) $display("FAIL reset_p4: got %h expected 0", {busy4, done4, ov4, ovf4, dout4});
        else pass_cnt++;
        reset = 1'b1;
        @(negedge clk);
        $display("reset checked");
    endtask

    task automatic test_start_unloaded();
        int b;
        b = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (busy1 || busy4) b++;
        end
        chk_cnt++;
        if (b !== 0) $display("FAIL start_unloaded: busy cycles %0d expected 0", b);
        else pass_cnt++;
        $display("start without operands checked");
    endtask

    task automatic test_identity();
        set_identity(); set_x_ramp();
        load_matrix(1'b0);
        load_vector();
        run_and_check("identity");
    endtask

    task automatic test_overflow();
        set_all_a(127); set_all_x(127);
        load_matrix(1'b0);
        load_vector();
        run_and_check("pos_ovf");
        set_all_a(-128); set_all_x(-128);
        load_matrix(1'b0);
        load_vector();
        run_and_check("neg_ovf");
    endtask

    task automatic test_vector_first();
        set_x_ramp();
        load_vector();
        set_all_a(1);
        load_matrix(1'b0);
        run_and_check("vec_first");
        set_all_x(2);
        load_vector();
        run_and_check("reuse_matrix");
    endtask

    task automatic test_reset_mid();
        int bad, b;
        set_identity(); set_x_ramp();
        load_matrix(1'b0);
        load_vector();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        chk_cnt++;
        if ({busy1, done1, ov1, ovf1, dout1} !== '0) $display("FAIL midreset_p1: got %h expected 0", {busy1, done1, ov1, ovf1, dout1});
        else pass_cnt++;
        chk_cnt++;
        if ({busy4, done4, ov4, ovf4, dout4} !== '0) $display("FAIL midreset_p4: got %h expected 0", {busy4, done4, ov4, ovf4, dout4});
        else pass_cnt++;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        bad = 0;
        repeat (80) begin
            @(negedge clk);
            if (done1 || done4 || ov1 || ov4) bad++;
        end
        chk_cnt++;
        if (bad !== 0) $display("FAIL midreset_quiet: output cycles %0d expected 0", bad);
        else pass_cnt++;
        b = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (busy1 || busy4) b++;
        end
        chk_cnt++;
        if (b !== 0) $display("FAIL midreset_invalid: busy cycles %0d expected 0", b);
        else pass_cnt++;
        load_matrix(1'b0);
        load_vector();
        run_and_check("after_reset");
    endtask

    task automatic test_priority();
        set_all_a(1);
        load_matrix(1'b0);
        set_x_ramp();
        load_vector();
        set_identity();
        load_matrix(1'b1);
        run_and_check("matrix_priority");
    endtask

    initial begin
        test_reset();
        test_start_unloaded();
        test_identity();
        test_overflow();
        test_vector_first();
        test_reset_mid();
        test_priority();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
